mips_cpu_load_store_unit: RTL
=============================

Name: mips_cpu_load_store_unit

Overview:
Consumes the decoder's memory controls (data_read, data_write, byte_enable, signextend_sel, lwlr_sel) plus the ALU address and rt value. Runs the resulting data-bus transaction as an Avalon-MM master with waitrequest, stalling the CPU until the access completes. Handles byte-lane steering, sub-word store replication, sign/zero extension and LWL/LWR merging, and returns the register writeback value. Sits between the execute stage and the data-memory port.

Parameters:
BUS_TIMEOUT, 0, cycles of continuous waitrequest before abort; 0 disables the timeout.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_read  in  1  load request (decoder data_read)
req_write  in  1  store request (decoder data_write)
req_byte_enable  in  4  access size: 0001 byte, 0011 half, 1111 word
req_signed  in  1  1 = sign-extend sub-word load
req_lwlr  in  2  11 LWL, 10 LWR, 0x normal
req_addr  in  32  byte address (ALU result)
req_wdata  in  32  store data / rt old value for LWL/LWR
avm_address  out  32  word-aligned address ({req_addr[31:2],2'b00})
avm_read  out  1  Avalon read
avm_write  out  1  Avalon write
avm_byteenable  out  4  lane enables
avm_writedata  out  32  lane-steered store data
avm_readdata  in  32  valid the cycle after read accepted
avm_waitrequest  in  1  slave not ready
stall  out  1  hold pipeline
load_data  out  32  formatted load result
load_valid  out  1  one-cycle pulse, load_data valid
addr_error  out  1  one-cycle pulse, misaligned access rejected
bus_error  out  1  one-cycle pulse, timeout abort

Behaviour:
- Reset values: state IDLE; avm_read, avm_write, load_valid, addr_error and bus_error are 0; load_data 0; the timeout counter is 0.
- The CPU holds its req_* inputs stable while stall=1.
- The unit is little-endian. off = req_addr[1:0].
- Misaligned accesses:
  - A half access is misaligned when off is odd.
  - A normal word access is misaligned when off != 0.
  - LWL/LWR accept any off and use byteenable 1111.
- Byteenable: byte = 0001<<off; half = 0011<<off; word = 1111.
- Writedata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- When req_read and req_write are both asserted, read has priority and the write is ignored.
- State IDLE:
  - On a request with a misaligned address: pulse addr_error next cycle, start no bus cycle, stay IDLE, stall=0.
  - On an aligned request: register address, lanes and data; go to BUS. stall=1 combinationally this cycle.
- State BUS:
  - avm_read or avm_write is driven from a register. Address, byteenable and writedata are held constant.
  - When waitrequest=0: a write goes to DONE; a read goes to RDATA. The command deasserts on the next edge.
  - While waitrequest=1, the counter increments. When BUS_TIMEOUT != 0 and the counter reaches BUS_TIMEOUT: drop the command, pulse bus_error, go to DONE with load_valid=0.
- State RDATA: capture avm_readdata, format it into load_data, go to DONE.
- State DONE: stall=0; load_valid=1 for loads only; next state IDLE. Inputs still asserted in DONE do not retrigger.
- Load formatting, with w = captured word:
  - byte b = w[8*off+7 : 8*off], sign- or zero-extended per req_signed.
  - half h = w[8*off+15 : 8*off], extended the same way.
  - word = w.
  - LWL: {w[8*off+7:0], rt[23-8*off:0]}; off=3 gives the full w.
  - LWR: {rt[31:32-8*off], w[31:8*off]}; off=0 gives the full w.
- stall = (IDLE & aligned request) | BUS | RDATA.
- Minimum latency with waitrequest=0:
  - load: 4 cycles, request cycle through DONE.
  - store: 3 cycles.
- Reset mid-transaction: return to IDLE on that edge, deassert the command, no load_valid or error pulses, counter cleared.

Test Plan:
- LW 0x100, waitrequest=0, readdata=0xDEADBEEF -> avm_read one cycle with address 0x100 and byteenable 1111, then load_data=0xDEADBEEF with load_valid; stall high for exactly 3 cycles.
- LB 0x103 signed with readdata 0x80112233, then LBU -> byteenable 1000; load_data 0xFFFFFF80, then 0x00000080.
- SH 0x202 wdata=0x1234ABCD, waitrequest high 3 cycles -> avm_write held 4 cycles with address 0x200, byteenable 1100, writedata 0xABCDABCD; stall releases one cycle after acceptance.
- LWL 0x301 with rt=0x11223344 and readdata=0xAABBCCDD -> load_data 0xCCDD3344. LWR 0x301, same data -> 0x11AABBCC.
- LW 0x102 -> addr_error pulse; no avm_read; stall never asserted beyond the request cycle. LH 0x101 -> same response.
- BUS_TIMEOUT=4, waitrequest stuck high -> bus_error after 4 BUS cycles, command dropped, no load_valid. Separately, reset asserted mid-BUS -> all outputs return to their reset values at the next edge.

Source files
------------

// File: rtl/mips_cpu_load_store_unit.sv
// mips_cpu_load_store_unit
//
// Purpose: runs the data-memory access for one MIPS load/store instruction
// as an Avalon-MM master. It steers byte lanes, replicates sub-word stores,
// sign/zero-extends sub-word loads and merges LWL/LWR results with the old
// rt value. The pipeline is held on stall until the bus access completes.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   req_read/write    load / store request from the decoder (read wins)
//   req_byte_enable   access size: 0001 byte, 0011 half, 1111 word
//   req_signed        sign-extend sub-word loads
//   req_lwlr          11 LWL, 10 LWR, 0x normal access
//   req_addr          byte address from the ALU
//   req_wdata         store data, or old rt value for LWL/LWR
//   avm_*             Avalon-MM master port (waitrequest flow control)
//   stall             holds the pipeline while the access is in flight
//   load_data         formatted load result
//   load_valid        one-cycle pulse when load_data is new
//   addr_error        one-cycle pulse for a rejected misaligned access
//   bus_error         one-cycle pulse when the bus timeout aborts an access
module mips_cpu_load_store_unit #(
  parameter int BUS_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [3:0]  req_byte_enable,
  input  logic        req_signed,
  input  logic [1:0]  req_lwlr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        addr_error,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RDATA = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0]  SZ_BYTE       = 2'd0;
  localparam logic [1:0]  SZ_HALF       = 2'd1;
  localparam logic [1:0]  SZ_WORD       = 2'd2;
  localparam logic [31:0] TIMEOUT_LIMIT = 32'(BUS_TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lwlr_q, lwlr_d;
  logic        is_read_q, is_read_d;
  logic [31:0] rt_q, rt_d;
  logic [3:0]  byteen_q, byteen_d;
  logic [31:0] wdata_q, wdata_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        addr_error_q, addr_error_d;
  logic        bus_error_q, bus_error_d;

  logic        req_any;
  logic        req_is_lwlr;
  logic        req_misaligned;
  logic [1:0]  req_off;
  logic [1:0]  req_size;
  logic [3:0]  req_lanes;
  logic [31:0] req_steered;

  // Little-endian extraction and merge. LWL shifts the low memory bytes up
  // into the top of the register; LWR shifts the high memory bytes down.
  // In both cases the bytes not supplied by memory come from the old rt.
  function automatic logic [31:0] format_load(
    input logic [31:0] w,
    input logic [31:0] rt,
    input logic [1:0]  off,
    input logic [1:0]  size,
    input logic [1:0]  lwlr,
    input logic        sgn
  );
    logic [4:0]  sh_lo;
    logic [4:0]  sh_hi;
    logic [31:0] lane;
    logic [31:0] res;
    sh_lo = {off, 3'b000};
    sh_hi = {~off, 3'b000};
    lane  = w >> sh_lo;
    if (lwlr == 2'b11) begin
      res = (w << sh_hi) | (rt & ~(32'hFFFF_FFFF << sh_hi));
    end else if (lwlr == 2'b10) begin
      res = lane | (rt & ~(32'hFFFF_FFFF >> sh_lo));
    end else begin
      case (size)
        SZ_BYTE: res = {{24{sgn & lane[7]}}, lane[7:0]};
        SZ_HALF: res = {{16{sgn & lane[15]}}, lane[15:0]};
        default: res = w;
      endcase
    end
    return res;
  endfunction

  // Request decode: size, alignment check, lane enables and store data.
  // LWL/LWR are always full-word bus reads, so they never misalign.
  always_comb begin
    req_any     = req_read | req_write;
    req_off     = req_addr[1:0];
    req_is_lwlr = req_read & req_lwlr[1];
    if (req_is_lwlr) begin
      req_size = SZ_WORD;
    end else begin
      case (req_byte_enable)
        4'b0001: req_size = SZ_BYTE;
        4'b0011: req_size = SZ_HALF;
        default: req_size = SZ_WORD;
      endcase
    end
    case (req_size)
      SZ_BYTE: req_misaligned = 1'b0;
      SZ_HALF: req_misaligned = req_off[0];
      default: req_misaligned = !req_is_lwlr && (req_off != 2'b00);
    endcase
    case (req_size)
      SZ_BYTE: begin
        req_lanes   = 4'b0001 << req_off;
        req_steered = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        req_lanes   = 4'b0011 << req_off;
        req_steered = {2{req_wdata[15:0]}};
      end
      default: begin
        req_lanes   = 4'b1111;
        req_steered = req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      off_q        <= '0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      lwlr_q       <= '0;
      is_read_q    <= 1'b0;
      rt_q         <= '0;
      byteen_q     <= '0;
      wdata_q      <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      cnt_q        <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      addr_error_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      off_q        <= off_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      lwlr_q       <= lwlr_d;
      is_read_q    <= is_read_d;
      rt_q         <= rt_d;
      byteen_q     <= byteen_d;
      wdata_q      <= wdata_d;
      read_q       <= read_d;
      write_q      <= write_d;
      cnt_q        <= cnt_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      addr_error_q <= addr_error_d;
      bus_error_q  <= bus_error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    off_d        = off_q;
    size_d       = size_q;
    signed_d     = signed_q;
    lwlr_d       = lwlr_q;
    is_read_d    = is_read_q;
    rt_d         = rt_q;
    byteen_d     = byteen_q;
    wdata_d      = wdata_q;
    read_d       = read_q;
    write_d      = write_q;
    cnt_d        = cnt_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    addr_error_d = 1'b0;
    bus_error_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (req_misaligned) begin
            addr_error_d = 1'b1;
          end else begin
            addr_d    = {req_addr[31:2], 2'b00};
            off_d     = req_off;
            size_d    = req_size;
            signed_d  = req_signed;
            lwlr_d    = req_is_lwlr ? req_lwlr : 2'b00;
            is_read_d = req_read;
            rt_d      = req_wdata;
            byteen_d  = req_lanes;
            wdata_d   = req_steered;
            read_d    = req_read;
            write_d   = !req_read;
            cnt_d     = '0;
            state_d   = BUS;
          end
        end
      end
      BUS: begin
        if (!avm_waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          cnt_d   = '0;
          state_d = is_read_q ? RDATA : DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
          // Abort on the cycle the count of stalled cycles hits the limit.
          if ((BUS_TIMEOUT != 0) && (cnt_d == TIMEOUT_LIMIT)) begin
            read_d      = 1'b0;
            write_d     = 1'b0;
            cnt_d       = '0;
            bus_error_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      RDATA: begin
        load_data_d  = format_load(avm_readdata, rt_q, off_q, size_q,
                                   lwlr_q, signed_q);
        load_valid_d = 1'b1;
        state_d      = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stall is combinational in IDLE so the request cycle itself is held.
  always_comb begin
    stall = ((state_q == IDLE) && req_any && !req_misaligned) ||
            (state_q == BUS) || (state_q == RDATA);
    avm_address    = addr_q;
    avm_read       = read_q;
    avm_write      = write_q;
    avm_byteenable = byteen_q;
    avm_writedata  = wdata_q;
    load_data      = load_data_q;
    load_valid     = load_valid_q;
    addr_error     = addr_error_q;
    bus_error      = bus_error_q;
  end

endmodule
